// File: rtl/ecc19_6_syndrome_decoder_if.sv
// rtl/ecc19_6_syndrome_decoder_if.sv - codeword input / corrected-message output bundle
interface ecc19_6_syndrome_decoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [18:0]      codeword_in;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       msg_out;
    logic             err_corrected;
    logic             err_uncorrectable;
    logic [4:0]       err_pos;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    modport master (
        output in_valid, codeword_in, out_ready,
        input  in_ready, out_valid, msg_out, err_corrected, err_uncorrectable,
               err_pos, corr_count, uncorr_count
    );

    modport slave (
        input  in_valid, codeword_in, out_ready,
        output in_ready, out_valid, msg_out, err_corrected, err_uncorrectable,
               err_pos, corr_count, uncorr_count
    );
endinterface

// File: rtl/ecc19_6_syndrome_decoder.sv
// rtl/ecc19_6_syndrome_decoder.sv - (19,6) syndrome decoder with serial single-error column search
module ecc19_6_syndrome_decoder #(
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ecc19_6_syndrome_decoder_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [4:0] NO_POS = 5'd31;

    state_t           state_q, state_d;
    logic [18:0]      cw_q, cw_d;
    logic [12:0]      syn_q, syn_d;
    logic [4:0]       idx_q, idx_d;
    logic [5:0]       msg_q, msg_d;
    logic             corr_q, corr_d;
    logic             uncorr_q, uncorr_d;
    logic [4:0]       pos_q, pos_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic [12:0]      syn_in;
    logic [18:0]      cw_flip;

    function automatic logic [12:0] calc_syndrome(input logic [18:0] c);
        logic [5:0]  b;
        logic [12:0] p;
        b     = c[5:0];
        p[0]  = b[0] ^ b[1] ^ b[4] ^ b[5];
        p[1]  = b[4] ^ b[5];
        p[2]  = b[2] ^ b[3] ^ b[5];
        p[3]  = b[0] ^ b[3] ^ b[4];
        p[4]  = b[1] ^ b[3] ^ b[4] ^ b[5];
        p[5]  = b[2] ^ b[4];
        p[6]  = b[0] ^ b[1] ^ b[5];
        p[7]  = b[0] ^ b[1] ^ b[4] ^ b[5];
        p[8]  = b[0] ^ b[3];
        p[9]  = b[2] ^ b[4];
        p[10] = b[1] ^ b[3] ^ b[4];
        p[11] = b[1] ^ b[2] ^ b[4] ^ b[5];
        p[12] = b[1] ^ b[2] ^ b[3];
        return c[18:6] ^ p;
    endfunction

    // Parity-check column k: message columns are fixed patterns, parity columns are unit vectors.
    function automatic logic [12:0] col_h(input logic [4:0] k);
        logic [12:0] h;
        case (k)
            5'd0:    h = 13'h01C9;
            5'd1:    h = 13'h1CD1;
            5'd2:    h = 13'h1A24;
            5'd3:    h = 13'h151C;
            5'd4:    h = 13'h0EBB;
            5'd5:    h = 13'h08D7;
            default: h = 13'd1 << (k - 5'd6);
        endcase
        return h;
    endfunction

    always_comb begin
        state_d      = state_q;
        cw_d         = cw_q;
        syn_d        = syn_q;
        idx_d        = idx_q;
        msg_d        = msg_q;
        corr_d       = corr_q;
        uncorr_d     = uncorr_q;
        pos_d        = pos_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        syn_in       = calc_syndrome(bus.codeword_in);
        cw_flip      = cw_q ^ (19'd1 << idx_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cw_d     = bus.codeword_in;
                    syn_d    = syn_in;
                    idx_d    = 5'd0;
                    msg_d    = bus.codeword_in[5:0];
                    corr_d   = 1'b0;
                    uncorr_d = 1'b0;
                    pos_d    = NO_POS;
                    state_d  = (syn_in == 13'd0) ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                if (syn_q == col_h(idx_q)) begin
                    cw_d    = cw_flip;
                    msg_d   = cw_flip[5:0];
                    corr_d  = 1'b1;
                    pos_d   = idx_q;
                    state_d = DONE;
                end else if (idx_q == 5'd18) begin
                    uncorr_d = 1'b1;
                    msg_d    = cw_q[5:0];
                    pos_d    = NO_POS;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    if (corr_q && (corr_cnt_q != '1))
                        corr_cnt_d = corr_cnt_q + CNT_W'(1);
                    if (uncorr_q && (uncorr_cnt_q != '1))
                        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cw_q         <= '0;
            syn_q        <= '0;
            idx_q        <= '0;
            msg_q        <= '0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            pos_q        <= NO_POS;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cw_q         <= cw_d;
            syn_q        <= syn_d;
            idx_q        <= idx_d;
            msg_q        <= msg_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            pos_q        <= pos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.in_ready          = (state_q == IDLE);
    assign bus.out_valid         = (state_q == DONE);
    assign bus.msg_out           = msg_q;
    assign bus.err_corrected     = corr_q;
    assign bus.err_uncorrectable = uncorr_q;
    assign bus.err_pos           = pos_q;
    assign bus.corr_count        = corr_cnt_q;
    assign bus.uncorr_count      = uncorr_cnt_q;
endmodule

// File: tb/tb_ecc19_6_syndrome_decoder.sv
// tb/tb_ecc19_6_syndrome_decoder.sv - scoreboard bench for the (19,6) syndrome decoder
module tb_ecc19_6_syndrome_decoder;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ecc19_6_syndrome_decoder_if #(.CNT_W(16)) bus ();
    ecc19_6_syndrome_decoder_if #(.CNT_W(2))  bus2 ();

    ecc19_6_syndrome_decoder #(.CNT_W(16)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
    ecc19_6_syndrome_decoder #(.CNT_W(2))  dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    typedef struct {
        logic [5:0] msg;
        logic       corr;
        logic       uncorr;
        logic [4:0] pos;
        int         lat;
    } exp_t;

    localparam logic [12:0] H_MSG [6] = '{13'h01C9, 13'h1CD1, 13'h1A24, 13'h151C, 13'h0EBB, 13'h08D7};

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_corr   = 0;
    int   exp_uncorr = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [12:0] tb_parity(input logic [5:0] b);
        logic [12:0] p;
        p = '0;
        for (int k = 0; k < 6; k++)
            if (b[k]) p = p ^ H_MSG[k];
        return p;
    endfunction

    function automatic logic [12:0] tb_col(input int k);
        return (k < 6) ? H_MSG[k] : (13'd1 << (k - 6));
    endfunction

    function automatic logic [18:0] encode(input logic [5:0] m);
        return {tb_parity(m), m};
    endfunction

    function automatic exp_t model(input logic [18:0] c);
        exp_t        e;
        logic [12:0] s;
        logic [18:0] f;
        s        = tb_parity(c[5:0]) ^ c[18:6];
        e.msg    = c[5:0];
        e.corr   = 1'b0;
        e.uncorr = 1'b0;
        e.pos    = 5'd31;
        e.lat    = 1;
        if (s != 13'd0) begin
            e.uncorr = 1'b1;
            e.lat    = 20;
            for (int k = 0; k < 19; k++) begin
                if (e.uncorr && s == tb_col(k)) begin
                    f        = c ^ (19'd1 << k);
                    e.uncorr = 1'b0;
                    e.corr   = 1'b1;
                    e.pos    = k[4:0];
                    e.lat    = k + 2;
                    e.msg    = f[5:0];
                end
            end
        end
        return e;
    endfunction

    task automatic send(input logic [18:0] c, input int hold);
        exp_t e;
        int   lat;
        sb.push_back(model(c));
        @(negedge clk);
        check_eq("in_ready_idle", bus.in_ready, 1);
        bus.in_valid    = 1'b1;
        bus.codeword_in = c;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.codeword_in = 19'($urandom);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check_eq("out_valid", bus.out_valid, 1);
        check_eq("latency", lat, e.lat);
        check_eq("msg_out", bus.msg_out, e.msg);
        check_eq("err_corrected", bus.err_corrected, e.corr);
        check_eq("err_uncorrectable", bus.err_uncorrectable, e.uncorr);
        check_eq("err_pos", bus.err_pos, e.pos);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid    = 1'b1;
            bus.codeword_in = 19'h07241;
            @(negedge clk);
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_in_ready", bus.in_ready, 0);
            check_eq("hold_msg", bus.msg_out, e.msg);
            check_eq("hold_pos", bus.err_pos, e.pos);
            check_eq("hold_flags", {bus.err_corrected, bus.err_uncorrectable}, {e.corr, e.uncorr});
            check_eq("hold_corr_count", bus.corr_count, exp_corr);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (e.corr)   exp_corr++;
        if (e.uncorr) exp_uncorr++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("valid_cleared", bus.out_valid, 0);
        check_eq("corr_count", bus.corr_count, exp_corr);
        check_eq("uncorr_count", bus.uncorr_count, exp_uncorr);
    endtask

    initial begin
        logic [18:0] c;
        int          lat;
        reset_n           = 1'b0;
        bus.in_valid      = 1'b0;
        bus.codeword_in   = '0;
        bus.out_ready     = 1'b0;
        bus2.in_valid     = 1'b0;
        bus2.codeword_in  = '0;
        bus2.out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_msg", bus.msg_out, 0);
        check_eq("rst_flags", {bus.err_corrected, bus.err_uncorrectable}, 0);
        check_eq("rst_pos", bus.err_pos, 31);
        check_eq("rst_counts", {bus.corr_count, bus.uncorr_count}, 0);
        reset_n = 1'b1;

        send(19'h00000, 0);
        send(19'h07241, 0);
        send(19'h07249, 0);
        send(19'h47241, 5);
        send(19'h07242, 0);
        for (int i = 0; i < 8; i++) begin
            int r;
            c = encode(6'($urandom_range(0, 63)));
            r = $urandom_range(0, 19);
            if (r < 19) c = c ^ (19'd1 << r);
            send(c, 0);
        end

        // Abort a search with reset: nothing is delivered and counters clear.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.codeword_in = 19'h47241;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("search_busy", bus.in_ready, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_corr   = 0;
        exp_uncorr = 0;
        check_eq("abort_in_ready", bus.in_ready, 1);
        check_eq("abort_out_valid", bus.out_valid, 0);
        check_eq("abort_counts", {bus.corr_count, bus.uncorr_count}, 0);
        send(19'h07249, 0);

        // Saturation of a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid    = 1'b1;
            bus2.codeword_in = 19'h07249;
            @(negedge clk);
            bus2.in_valid = 1'b0;
            lat = 0;
            while (!bus2.out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check_eq("sat_out_valid", bus2.out_valid, 1);
            bus2.out_ready = 1'b1;
            @(negedge clk);
            bus2.out_ready = 1'b0;
            check_eq("sat_corr_count", bus2.corr_count, (i + 1 > 3) ? 3 : i + 1);
        end
        check_eq("sat_uncorr_count", bus2.uncorr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
